// File: rtl/fc_layer_sequencer_if.sv
// fc_layer_sequencer_if: scheduler-side request and PE/weight-ROM-side feed signals of one FC layer pass.
interface fc_layer_sequencer_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int INPUT_NODES = 100,
  parameter int ADDR_WIDTH  = 7
);
  logic                              start;
  logic [DATA_WIDTH*INPUT_NODES-1:0] input_fc;
  logic                              busy;
  logic                              pe_clear;
  logic                              pe_en;
  logic [DATA_WIDTH-1:0]             selected_input;
  logic [ADDR_WIDTH-1:0]             weight_addr;
  logic                              done;
  logic                              result_valid;
  modport master (output start, output input_fc, input busy, input pe_clear, input pe_en,
                  input selected_input, input weight_addr, input done, input result_valid);
  modport slave  (input start, input input_fc, output busy, output pe_clear, output pe_en,
                  output selected_input, output weight_addr, output done, output result_valid);
endinterface

// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer: latches a layer input vector, clears the PEs, feeds words high-to-low, drains, then signals done.
module fc_layer_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int INPUT_NODES = 100,
  parameter int ADDR_WIDTH  = 7,
  parameter int PE_LATENCY  = 4
) (
  input logic               clk,
  input logic               reset,
  fc_layer_sequencer_if.slave bus
);
  localparam int DW = (PE_LATENCY > 1) ? $clog2(PE_LATENCY) : 1;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
  state_t                            state_q, state_d;
  logic [ADDR_WIDTH-1:0]             idx_q, idx_d;
  logic [DW-1:0]                     drain_q, drain_d;
  logic [DATA_WIDTH*INPUT_NODES-1:0] buf_q, buf_d;
  logic                              rv_q, rv_d;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    buf_d   = buf_q;
    rv_d    = rv_q;
    case (state_q)
      IDLE: if (bus.start) begin
        buf_d   = bus.input_fc;
        rv_d    = 1'b0;
        idx_d   = ADDR_WIDTH'(INPUT_NODES - 1);
        state_d = CLEAR;
      end
      CLEAR: state_d = FEED;
      FEED: if (idx_q == '0) begin
        drain_d = DW'(PE_LATENCY - 1);
        state_d = DRAIN;
      end else idx_d = idx_q - 1'b1;
      DRAIN: if (drain_q == '0) state_d = DONE;
             else drain_d = drain_q - 1'b1;
      DONE: begin
        rv_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      drain_q <= '0;
      buf_q   <= '0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
      buf_q   <= buf_d;
      rv_q    <= rv_d;
    end
  end
  assign bus.busy           = state_q != IDLE;
  assign bus.pe_clear       = state_q == CLEAR;
  assign bus.pe_en          = state_q == FEED;
  assign bus.selected_input = (state_q == FEED) ? buf_q[DATA_WIDTH*idx_q +: DATA_WIDTH] : '0;
  assign bus.weight_addr    = (state_q == FEED) ? idx_q : '0;
  assign bus.done           = state_q == DONE;
  assign bus.result_valid   = rv_q;
endmodule

// File: tb/tb_fc_layer_sequencer.sv
// tb_fc_layer_sequencer: directed scenarios plus random start/reset traffic against a pass-timeline reference model.
module tb_fc_layer_sequencer;
  localparam int N = 4;
  localparam int L = 2;
  localparam int DWD = 32;
  localparam int AW = 2;
  logic clk, reset;
  int vectors = 0, errs = 0, cycn = 0, t0;
  int dq[$];
  bit m_active, m_rv;
  int m_t;
  logic [DWD*N-1:0] m_lat;
  logic [31:0] fw [4] = '{32'h0, 32'h3F800000, 32'h40000000, 32'h40400000};
  fc_layer_sequencer_if #(.DATA_WIDTH(DWD), .INPUT_NODES(N), .ADDR_WIDTH(AW)) bus ();
  fc_layer_sequencer #(.DATA_WIDTH(DWD), .INPUT_NODES(N), .ADDR_WIDTH(AW), .PE_LATENCY(L))
    dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s cycle=%0d got=%h expected=%h", tag, cycn, got, exp);
    end
  endtask
  // A pass is modelled as its elapsed cycle count t since acceptance: 1 clear, 2..N+1 feed, then L drain, then done.
  task automatic cyc(input logic st, input logic rs);
    int k;
    logic [38:0] e;
    bus.start = st;
    reset = rs;
    @(posedge clk);
    if (rs) begin
      m_active = 0; m_t = 0; m_rv = 0; m_lat = '0;
    end else if (!m_active) begin
      if (st) begin m_active = 1; m_t = 1; m_lat = bus.input_fc; m_rv = 0; end
    end else if (m_t == N + L + 2) begin
      m_active = 0; m_rv = 1;
    end else m_t++;
    cycn++;
    #1;
    k = N + 1 - m_t;
    e = '0;
    e[38] = m_active;
    e[37] = m_active && m_t == 1;
    e[36] = m_active && m_t >= 2 && m_t <= N + 1;
    e[35] = m_active && m_t == N + L + 2;
    e[34] = m_rv;
    if (e[36]) begin
      e[33:32] = AW'(k);
      e[31:0]  = m_lat[DWD*k +: DWD];
    end
    chk("outs", {25'd0, bus.busy, bus.pe_clear, bus.pe_en, bus.done, bus.result_valid,
                 bus.weight_addr, bus.selected_input}, {25'd0, e});
    if (bus.done === 1'b1) dq.push_back(cycn);
  endtask
  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.input_fc = '0;
    cyc(0, 1);
    cyc(0, 1);
    repeat (5) cyc(0, 0);
    chk("idle", {bus.busy, bus.done, bus.result_valid, bus.pe_en, bus.pe_clear, bus.selected_input}, '0);
    bus.input_fc = {fw[3], fw[2], fw[1], fw[0]};
    dq.delete();
    t0 = cycn;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) bus.input_fc = '1;
      cyc(c == 0, 0);
      if (c + 1 == 1) chk("clear", bus.pe_clear, 1);
      if (c + 1 >= 2 && c + 1 <= 5)
        chk("feed", {bus.pe_en, bus.weight_addr, bus.selected_input},
            {1'b1, AW'(5 - (c + 1)), fw[5 - (c + 1)]});
      if (c + 1 == 6 || c + 1 == 7) chk("drain_en", bus.pe_en, 0);
    end
    chk("done_n", dq.size(), 1);
    chk("done_at", (dq.size() > 0) ? dq[0] - t0 : -1, 8);
    chk("rv_hold", bus.result_valid, 1);
    bus.input_fc = {$urandom, $urandom, $urandom, $urandom};
    dq.delete();
    t0 = cycn;
    for (int c = 0; c < 14; c++) cyc(c == 0 || c == 4 || c == 8, 0);
    chk("ign_done_n", dq.size(), 1);
    chk("ign_done_at", (dq.size() > 0) ? dq[0] - t0 : -1, 8);
    cyc(1, 0);
    chk("restart_clear", bus.pe_clear, 1);
    repeat (12) cyc(0, 0);
    dq.delete();
    t0 = cycn;
    for (int c = 0; c < 30; c++) begin
      cyc(1, 0);
      if (c + 1 == 10) chk("held_rv_drop", bus.result_valid, 0);
    end
    bus.start = 1'b0;
    chk("held_first", (dq.size() > 0) ? dq[0] - t0 : -1, 8);
    chk("held_second", (dq.size() > 1) ? dq[1] - t0 : -1, 17);
    repeat (12) cyc(0, 0);
    dq.delete();
    t0 = cycn;
    cyc(1, 0);
    repeat (5) cyc(0, 0);
    cyc(0, 1);
    chk("rst_abort", {bus.busy, bus.done, bus.result_valid, bus.pe_en, bus.pe_clear, bus.selected_input}, '0);
    t0 = cycn;
    cyc(1, 0);
    repeat (10) cyc(0, 0);
    chk("rst_done_n", dq.size(), 1);
    chk("rst_done_at", (dq.size() > 0) ? dq[0] - t0 : -1, 8);
    for (int c = 0; c < 400; c++) begin
      bus.input_fc = {$urandom, $urandom, $urandom, $urandom};
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
    end
    repeat (12) cyc(0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
